// File: rtl/ram_pkg.sv
// Shared definitions for the single-port RAM family: FSM encodings and the
// address-width derivation used by every RAM variant.
package ram_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } ram_state_e;

    // Address width for a word count; a floor of one bit keeps ports legal.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ram_core.sv
// Bare inferred block-RAM array: one masked write port and a registered read
// port on the same address, deliberately without reset so the array maps to BRAM.
module ram_core import ram_pkg::*; #(
    parameter  int WIDTH  = 16,
    parameter  int DEPTH  = 256,
    localparam int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  din,
    input  logic [WIDTH-1:0]  wmask,
    output logic [WIDTH-1:0]  q
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Masked write and registered read; q holds its value when no read occurs.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= (mem_r[addr] & ~wmask) | (din & wmask);
        end
        if (re) begin
            q <= mem_r[addr];
        end
    end

endmodule

// File: rtl/ram_sp_clr.sv
// Parametrised single-port RAM with per-bit write mask, req/ready handshake,
// read-valid strobe and an optional clear engine enabled by RAM_CLEAR_EN.
module ram_sp_clr import ram_pkg::*; #(
    parameter  int WIDTH  = 16,
    parameter  int DEPTH  = 256,
    localparam int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  din,
    input  logic [WIDTH-1:0]  wmask,
    input  logic              clr,
    output logic              ready,
    output logic              busy,
    output logic [WIDTH-1:0]  dout,
    output logic              dout_valid
);

    logic              ready_s;
    logic              busy_s;
    logic              clear_wr_s;
    logic [ADDR_W-1:0] clr_ptr_s;
    logic              acc_s;
    logic              core_we_s;
    logic              core_re_s;
    logic [ADDR_W-1:0] core_addr_s;
    logic [WIDTH-1:0]  core_din_s;
    logic [WIDTH-1:0]  core_mask_s;
    logic [WIDTH-1:0]  core_q_s;
    logic              dout_valid_r;
    logic              dout_zero_r;

`ifdef RAM_CLEAR_EN
    ram_state_e        state_r;
    logic [ADDR_W-1:0] clr_ptr_r;

    // Clear FSM: reset lands in CLEAR so the array is zeroed after every reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_CLEAR;
            clr_ptr_r <= {ADDR_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (clr) begin
                        state_r <= ST_CLEAR;
                    end
                    clr_ptr_r <= {ADDR_W{1'b0}};
                end
                ST_CLEAR: begin
                    clr_ptr_r <= clr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (clr_ptr_r == ADDR_W'(DEPTH - 1)) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    clr_ptr_r <= {ADDR_W{1'b0}};
                end
            endcase
        end
    end

    assign busy_s     = (state_r == ST_CLEAR);
    assign ready_s    = (state_r == ST_IDLE) & ~clr;
    // Gated by rst_n so edges seen while reset is held never touch the array.
    assign clear_wr_s = busy_s & rst_n;
    assign clr_ptr_s  = clr_ptr_r;
`else
    logic ready_r;
    logic unused_clr_s;

    // Without the clear engine the port opens on the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= 1'b1;
        end
    end

    assign busy_s       = 1'b0;
    assign ready_s      = ready_r;
    assign clear_wr_s   = 1'b0;
    assign clr_ptr_s    = {ADDR_W{1'b0}};
    assign unused_clr_s = clr;
`endif

    assign acc_s = req & ready_s;

    // Array port mux: the clear engine owns the port while it runs.
    always_comb begin
        core_we_s   = 1'b0;
        core_re_s   = 1'b0;
        core_addr_s = addr;
        core_din_s  = din;
        core_mask_s = wmask;
        if (clear_wr_s) begin
            core_we_s   = 1'b1;
            core_addr_s = clr_ptr_s;
            core_din_s  = {WIDTH{1'b0}};
            core_mask_s = {WIDTH{1'b1}};
        end else begin
            core_we_s = acc_s & we;
            core_re_s = acc_s & ~we;
        end
    end

    ram_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_core (
        .clk   (clk),
        .we    (core_we_s),
        .re    (core_re_s),
        .addr  (core_addr_s),
        .din   (core_din_s),
        .wmask (core_mask_s),
        .q     (core_q_s)
    );

    // Read strobe, plus a flag that presents zero until the first read after
    // reset, since the core's read register itself has no reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_valid_r <= 1'b0;
            dout_zero_r  <= 1'b1;
        end else begin
            dout_valid_r <= acc_s & ~we;
            if (acc_s & ~we) begin
                dout_zero_r <= 1'b0;
            end else begin
                dout_zero_r <= dout_zero_r;
            end
        end
    end

    assign ready      = ready_s;
    assign busy       = busy_s;
    assign dout       = dout_zero_r ? {WIDTH{1'b0}} : core_q_s;
    assign dout_valid = dout_valid_r;

endmodule

// File: tb/tb_ram_sp_clr.sv
// Directed, table-driven bench for ram_sp_clr (WIDTH=16, DEPTH=256); covers
// the clear engine when RAM_CLEAR_EN is defined, the plain port otherwise.
module tb_ram_sp_clr;

`ifdef RAM_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    typedef struct packed {
        logic        req;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] din;
        logic [15:0] wmask;
        logic        exp_dv;
        logic        chk_dout;
        logic [15:0] exp_dout;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  addr = 8'h00;
    logic [15:0] din = 16'h0000;
    logic [15:0] wmask = 16'h0000;
    logic        clr = 1'b0;
    logic        ready;
    logic        busy;
    logic [15:0] dout;
    logic        dout_valid;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vec [17];

    ram_sp_clr #(.WIDTH(16), .DEPTH(256)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .din        (din),
        .wmask      (wmask),
        .clr        (clr),
        .ready      (ready),
        .busy       (busy),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v, input int idx);
        req   = v.req;
        we    = v.we;
        addr  = v.addr;
        din   = v.din;
        wmask = v.wmask;
        tick();
        req = 1'b0;
        check($sformatf("vec%0d dout_valid", idx), {31'd0, dout_valid}, {31'd0, v.exp_dv});
        if (v.chk_dout) begin
            check($sformatf("vec%0d dout", idx), {16'd0, dout}, {16'd0, v.exp_dout});
        end
        check($sformatf("vec%0d ready", idx), {31'd0, ready}, 32'd1);
    endtask

    // Counts edges until busy drops, pulsing clr once at clr_at (negative = never).
    task automatic count_busy(input string nm, input int clr_at);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            clr = (n == clr_at);
            tick();
            n++;
        end
        clr = 1'b0;
        check({nm, " clear length"}, n, 32'd256);
        check({nm, " ready after clear"}, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        // req, we, addr, din, wmask, exp_dv, chk_dout, exp_dout
        vec[0]  = '{1'b1, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b1, CLR_EN, 16'h0000};
        vec[1]  = '{1'b1, 1'b0, 8'hFF, 16'h0000, 16'h0000, 1'b1, CLR_EN, 16'h0000};
        vec[2]  = '{1'b1, 1'b1, 8'h12, 16'hBEEF, 16'hFFFF, 1'b0, CLR_EN, 16'h0000};
        vec[3]  = '{1'b1, 1'b1, 8'h12, 16'h0000, 16'h00F0, 1'b0, CLR_EN, 16'h0000};
        vec[4]  = '{1'b1, 1'b0, 8'h12, 16'h0000, 16'h0000, 1'b1, 1'b1,   16'hBE0F};
        vec[5]  = '{1'b1, 1'b1, 8'h10, 16'h1111, 16'hFFFF, 1'b0, 1'b1,   16'hBE0F};
        vec[6]  = '{1'b1, 1'b1, 8'h11, 16'h2222, 16'hFFFF, 1'b0, 1'b1,   16'hBE0F};
        vec[7]  = '{1'b1, 1'b1, 8'h12, 16'h3333, 16'hFFFF, 1'b0, 1'b1,   16'hBE0F};
        vec[8]  = '{1'b1, 1'b0, 8'h10, 16'h0000, 16'h0000, 1'b1, 1'b1,   16'h1111};
        vec[9]  = '{1'b1, 1'b0, 8'h11, 16'h0000, 16'h0000, 1'b1, 1'b1,   16'h2222};
        vec[10] = '{1'b1, 1'b0, 8'h12, 16'h0000, 16'h0000, 1'b1, 1'b1,   16'h3333};
        vec[11] = '{1'b0, 1'b0, 8'h10, 16'h0000, 16'h0000, 1'b0, 1'b1,   16'h3333};
        vec[12] = '{1'b1, 1'b1, 8'h20, 16'h0000, 16'hFFFF, 1'b0, 1'b1,   16'h3333};
        vec[13] = '{1'b1, 1'b1, 8'h20, 16'hA5A5, 16'hFF00, 1'b0, 1'b1,   16'h3333};
        vec[14] = '{1'b1, 1'b0, 8'h20, 16'h0000, 16'h0000, 1'b1, 1'b1,   16'hA500};
        vec[15] = '{1'b1, 1'b1, 8'h20, 16'hFFFF, 16'h0001, 1'b0, 1'b1,   16'hA500};
        vec[16] = '{1'b1, 1'b0, 8'h20, 16'h0000, 16'h0000, 1'b1, 1'b1,   16'hA501};

        #1 rst_n = 1'b0;
        #1;
        check("rst ready", {31'd0, ready}, 32'd0);
        check("rst busy", {31'd0, busy}, {31'd0, CLR_EN});
        check("rst dout", {16'd0, dout}, 32'd0);
        check("rst dout_valid", {31'd0, dout_valid}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        if (CLR_EN) begin
            count_busy("powerup", -1);
        end else begin
            tick();
            check("ready first edge", {31'd0, ready}, 32'd1);
            check("busy tied low", {31'd0, busy}, 32'd0);
        end

        for (int i = 0; i < 17; i++) begin
            apply(vec[i], i);
        end

        if (CLR_EN) begin
            // Reset asserted 100 cycles into a commanded clear.
            clr = 1'b1;
            tick();
            clr = 1'b0;
            check("clr busy", {31'd0, busy}, 32'd1);
            repeat (99) tick();
            rst_n = 1'b0;
            #1;
            check("midrst dout", {16'd0, dout}, 32'd0);
            check("midrst dout_valid", {31'd0, dout_valid}, 32'd0);
            check("midrst busy", {31'd0, busy}, 32'd1);
            tick();
            tick();
            check("midrst hold dout", {16'd0, dout}, 32'd0);
            rst_n = 1'b1;
            count_busy("restart", -1);

            apply('{1'b1, 1'b1, 8'h40, 16'h1234, 16'hFFFF, 1'b0, 1'b1, 16'h0000}, 20);
            apply('{1'b1, 1'b0, 8'h40, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h1234}, 21);

            // clr and a read together: the read is refused and the clear runs.
            req  = 1'b1;
            we   = 1'b0;
            addr = 8'h40;
            clr  = 1'b1;
            #1;
            check("clr blocks ready", {31'd0, ready}, 32'd0);
            tick();
            req = 1'b0;
            clr = 1'b0;
            check("clr+req busy", {31'd0, busy}, 32'd1);
            check("clr+req no strobe", {31'd0, dout_valid}, 32'd0);
            count_busy("clr+req", 50);

            apply('{1'b1, 1'b0, 8'h40, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000}, 22);
            apply('{1'b1, 1'b0, 8'h12, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000}, 23);
        end else begin
            // clr has no effect without the clear engine.
            clr = 1'b1;
            #1;
            check("clr ignored ready", {31'd0, ready}, 32'd1);
            apply('{1'b1, 1'b0, 8'h10, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h1111}, 30);
            check("clr ignored busy", {31'd0, busy}, 32'd0);
            clr = 1'b0;
            tick();
            check("clr low ready", {31'd0, ready}, 32'd1);
            apply('{1'b1, 1'b0, 8'h12, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h3333}, 31);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
